// File: rtl/tmds_pkg.sv
// Shared constants, mode encodings and lane request type for the TMDS lane serializer.
package tmds_pkg;
  localparam int TMDS_WORD_W = 10;
  localparam logic [TMDS_WORD_W-1:0] CLOCK_WORD = 10'b0000011111;
  localparam logic [2:0][TMDS_WORD_W-1:0] DEFAULT_PATTERN =
    {10'b1100110011, 10'b1010101010, 10'b0101010101};

  localparam logic [1:0] MODE_STREAM  = 2'd0;
  localparam logic [1:0] MODE_PATTERN = 2'd1;
  localparam logic [1:0] MODE_REPEAT  = 2'd2;

  typedef struct packed {
    logic                   load;
    logic [TMDS_WORD_W-1:0] word;
  } lane_req_t;

  // Lanes above 2 reuse lane 0's test word.
  function automatic logic [TMDS_WORD_W-1:0] lane_pattern(
    input logic [2:0][TMDS_WORD_W-1:0] pat, input int k);
    logic [1:0] idx;
    idx = 2'(k);
    if (k < 3) return pat[idx];
    return pat[0];
  endfunction
endpackage

// File: rtl/tmds_lane_shifter.sv
// One lane: active word register, phase slice mux and registered serial output.
module tmds_lane_shifter
  import tmds_pkg::*;
#(
  parameter int                     C_bits   = 2,
  parameter int                     PH_W     = 3,
  parameter logic [TMDS_WORD_W-1:0] RST_WORD = '0
) (
  input  logic              clk_shift,
  input  logic              reset,
  input  lane_req_t         req,
  input  logic [PH_W-1:0]   phase,
`ifdef TMDS_SER_POLARITY_EN
  input  logic              pol_ld,
  input  logic              pol,
`endif
  output logic [C_bits-1:0] out_bits
);
  logic [TMDS_WORD_W-1:0] active;
  logic [3:0]             bit_idx;
  logic [C_bits-1:0]      slice;
  logic [C_bits-1:0]      inv_mask;

  assign bit_idx = 4'(int'(phase) * C_bits);
  assign slice   = active[bit_idx +: C_bits];

`ifdef TMDS_SER_POLARITY_EN
  // Polarity latches with the word so a word never changes polarity mid-flight.
  logic pol_q;
  always_ff @(posedge clk_shift) begin
    if (reset)       pol_q <= 1'b0;
    else if (pol_ld) pol_q <= pol;
  end
  assign inv_mask = {C_bits{pol_q}};
`else
  assign inv_mask = '0;
`endif

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      active   <= RST_WORD;
      out_bits <= '0;
    end else begin
      if (req.load) active <= req.word;
      out_bits <= slice ^ inv_mask;
    end
  end
endmodule

// File: rtl/tmds_lane_serializer.sv
// N-lane TMDS serializer with one-deep bundle buffer, pattern/repeat modes and sticky underflow.
// Optional per-lane output inversion when TMDS_SER_POLARITY_EN is defined.
module tmds_lane_serializer
  import tmds_pkg::*;
#(
  parameter int                             C_lanes      = 4,
  parameter int                             C_bits       = 2,
  parameter int                             C_clock_lane = 1,
  parameter logic [2:0][TMDS_WORD_W-1:0]    C_pattern    = DEFAULT_PATTERN
) (
  input  logic                          clk_shift,
  input  logic                          reset,
  input  logic [1:0]                    mode_sel,
  input  logic [TMDS_WORD_W*C_lanes-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [C_bits*C_lanes-1:0]     out_data,
  output logic                          word_strobe,
  output logic                          underflow,
`ifdef TMDS_SER_POLARITY_EN
  input  logic [C_lanes-1:0]            pol_inv,
`endif
  input  logic                          underflow_clr
);
  localparam int P      = TMDS_WORD_W / C_bits;
  localparam int PH_W   = (P > 1) ? $clog2(P) : 1;
  localparam int STAGES = 1;

  if (!(C_bits == 1 || C_bits == 2 || C_bits == 5)) begin : g_bad_bits
    $error("tmds_lane_serializer: C_bits must be 1, 2 or 5");
  end

  logic [PH_W-1:0]                       phase;
  logic                                  boundary;
  logic [C_lanes-1:0][TMDS_WORD_W-1:0]   buffer;
  logic                                  buf_full;
  logic                                  stream, pattern_mode;
  logic                                  accept, drain, starve, load_en;
  logic [STAGES:0]                       vld_pipe;

  assign boundary     = (phase == PH_W'(P - 1));
  assign stream       = (mode_sel == MODE_STREAM);
  assign pattern_mode = !stream && (mode_sel != MODE_REPEAT);
  // Outside stream mode a full buffer is held, so it must not be overwritten.
  assign in_ready     = !reset && (!buf_full || (boundary && stream));
  assign accept       = in_valid && in_ready;
  assign drain        = boundary && stream && buf_full;
  assign starve       = boundary && stream && !buf_full;
  assign load_en      = drain || (boundary && pattern_mode);
  assign word_strobe  = vld_pipe[STAGES];

  always_ff @(posedge clk_shift) begin
    if (reset) begin
      phase     <= '0;
      buf_full  <= 1'b0;
      buffer    <= '0;
      underflow <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      phase     <= boundary ? '0 : phase + 1'b1;
      if (accept) buffer <= in_data;
      buf_full  <= accept || (buf_full && !drain);
      underflow <= starve || (underflow && !underflow_clr);
      // Strobe lines up with the first output slice of the freshly loaded word.
      vld_pipe  <= {vld_pipe[STAGES-1:0], boundary};
    end
  end

  for (genvar k = 0; k < C_lanes; k++) begin : g_lane
    localparam bit IS_CLK = (C_clock_lane == 1) && (k == C_lanes - 1);
    localparam logic [TMDS_WORD_W-1:0] LANE_WORD = IS_CLK ? CLOCK_WORD : lane_pattern(C_pattern, k);
    lane_req_t req;

    always_comb begin
      req.load = load_en;
      req.word = drain ? buffer[k] : LANE_WORD;
      if (IS_CLK) req.word = CLOCK_WORD;
    end

    tmds_lane_shifter #(
      .C_bits   (C_bits),
      .PH_W     (PH_W),
      .RST_WORD (LANE_WORD)
    ) u_lane (
      .clk_shift (clk_shift),
      .reset     (reset),
      .req       (req),
      .phase     (phase),
`ifdef TMDS_SER_POLARITY_EN
      .pol_ld    (boundary),
      .pol       (pol_inv[k]),
`endif
      .out_bits  (out_data[C_bits*k +: C_bits])
    );
  end
endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Randomized scoreboard bench: word-level reference model predicts each cycle's outputs.
module tb_tmds_lane_serializer;
  import tmds_pkg::*;

  localparam int L = 4;
  localparam int B = 2;
  localparam int P = 10 / B;

  logic             clk_shift = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode_sel = 2'd1;
  logic [10*L-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             underflow_clr = 1'b0;
  logic             in_ready, word_strobe, underflow;
  logic [B*L-1:0]   out_data;

  tmds_lane_serializer #(.C_lanes(L), .C_bits(B), .C_clock_lane(1)) dut (
    .clk_shift     (clk_shift),
    .reset         (reset),
    .mode_sel      (mode_sel),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .word_strobe   (word_strobe),
    .underflow     (underflow),
`ifdef TMDS_SER_POLARITY_EN
    .pol_inv       ('0),
`endif
    .underflow_clr (underflow_clr)
  );

  always #5 clk_shift = ~clk_shift;

  typedef struct {
    logic [B*L-1:0] out;
    logic           stb;
    logic           uf;
  } exp_t;

  exp_t            sb[$];
  logic [10*L-1:0] pend[$];
  logic [9:0]      cur[L];
  int              ph = 0;
  bit              uf = 0;
  bit              booted = 0;
  int              checks = 0;
  int              errors = 0;
  int              strobes = 0;
  int              delivered = 0;

  function automatic logic [9:0] pat(int l);
    if (l == L - 1) return 10'b0000011111;
    case (l)
      1:       return 10'b1010101010;
      2:       return 10'b1100110011;
      default: return 10'b0101010101;
    endcase
  endfunction

  // Reference model: words are whole values, the phase is the cycle count modulo P.
  always @(posedge clk_shift) begin : model
    exp_t            e;
    bit              last, rdy, set;
    logic [10*L-1:0] w;
    logic [B-1:0]    s;
    e.out = '0; e.stb = 1'b0; e.uf = 1'b0;
    if (reset) begin
      ph = 0; pend.delete(); uf = 0; booted = 0;
      for (int l = 0; l < L; l++) cur[l] = pat(l);
    end else begin
      set  = 0;
      last = (ph == P - 1);
      rdy  = (pend.size() == 0) || (last && mode_sel == 2'd0);
      for (int l = 0; l < L; l++) begin
        s = B'(cur[l] >> (ph * B));
        e.out = e.out | ((B*L)'(s) << (l * B));
      end
      e.stb = (ph == 0) && booted;
      if (last) begin
        booted = 1;
        if (mode_sel == 2'd0) begin
          if (pend.size() != 0) begin
            w = pend.pop_front();
            delivered++;
            for (int l = 0; l < L - 1; l++) cur[l] = 10'(w >> (l * 10));
          end else set = 1;
        end else if (mode_sel != 2'd2) begin
          for (int l = 0; l < L; l++) cur[l] = pat(l);
        end
      end
      if (in_valid && rdy) pend.push_back(in_data);
      uf   = set ? 1'b1 : (underflow_clr ? 1'b0 : uf);
      e.uf = uf;
      ph   = (ph + 1) % P;
    end
    sb.push_back(e);
  end

  always @(negedge clk_shift) begin : monitor
    exp_t e;
    logic rdy_exp;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_data !== e.out) begin
        errors++;
        $display("FAIL out_data t=%0t got %b expected %b", $time, out_data, e.out);
      end
      checks++;
      if (word_strobe !== e.stb) begin
        errors++;
        $display("FAIL word_strobe t=%0t got %b expected %b", $time, word_strobe, e.stb);
      end
      checks++;
      if (underflow !== e.uf) begin
        errors++;
        $display("FAIL underflow t=%0t got %b expected %b", $time, underflow, e.uf);
      end
      if (word_strobe === 1'b1) strobes++;
    end
    rdy_exp = !reset && ((pend.size() == 0) || (ph == P - 1 && mode_sel == 2'd0));
    checks++;
    if (in_ready !== rdy_exp) begin
      errors++;
      $display("FAIL in_ready t=%0t got %b expected %b", $time, in_ready, rdy_exp);
    end
  end

  initial begin
    repeat (3) @(posedge clk_shift);
    #2 reset = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 300; c++) begin
        @(posedge clk_shift);
        #2;
        reset         = 1'b0;
        in_data       = {$urandom, $urandom};
        underflow_clr = 1'b0;
        case (seg)
          0: begin mode_sel = 2'd1; in_valid = 1'b0; end
          1: begin mode_sel = 2'd0; in_valid = 1'b1; end
          2: begin
            mode_sel = 2'd0;
            in_valid = ($urandom % 6) == 0;
            underflow_clr = ($urandom % 8) == 0;
          end
          3: begin
            mode_sel = 2'($urandom % 4);
            in_valid = $urandom % 2;
            underflow_clr = ($urandom % 10) == 0;
          end
          4: begin
            mode_sel = 2'($urandom % 4);
            in_valid = $urandom % 2;
            underflow_clr = ($urandom % 10) == 0;
            reset = ($urandom % 40) == 0;
          end
          default: begin
            mode_sel = (($urandom % 8) == 0) ? 2'd2 : 2'd0;
            in_valid = ($urandom % 3) == 0;
            underflow_clr = ($urandom % 5) == 0;
          end
        endcase
      end
    end
    @(posedge clk_shift);
    #2 in_valid = 1'b0; reset = 1'b0;
    repeat (4) @(negedge clk_shift);
    checks++;
    if (strobes == 0) begin
      errors++;
      $display("FAIL strobe_activity got %0d strobes expected nonzero", strobes);
    end
    checks++;
    if (delivered == 0) begin
      errors++;
      $display("FAIL stream_delivery got %0d bundles expected nonzero", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
